// File: rtl/vsfx_issue_arb_pkg.sv
// Shared widths and the tracking-entry layout for the vsfx issue arbiter.
package vsfx_issue_arb_pkg;
    localparam int VSFX_INS_W = 8;
    localparam int VSFX_DW    = 128;
    localparam int VSFX_TAG_W = 4;

    typedef struct packed {
        logic                  valid;
        logic                  id;
        logic [VSFX_TAG_W-1:0] tag;
    } vsfx_trk_t;
endpackage

// File: rtl/vsfx_rr_arb2.sv
// Two-way round-robin arbiter with a 1-bit priority pointer; grants are combinational.
module vsfx_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       block,
    output logic [1:0] grant
);
    logic ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|grant) begin
            // Priority passes to whichever requester did not win.
            ptr <= grant[0];
        end
    end

    always_comb begin
        grant = 2'b00;
        if (!rst && !block) begin
            if (valid[0] && valid[1]) begin
                grant[ptr] = 1'b1;
            end else begin
                grant = valid;
            end
        end
    end
endmodule

// File: rtl/vsfx_issue_arb.sv
// Arbitrates two requesters onto one pipelined vsfx unit and routes results back by tag.
module vsfx_issue_arb
    import vsfx_issue_arb_pkg::*;
#(
    parameter int VSFX_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [VSFX_DW-1:0]    req0_vra,
    input  logic [VSFX_DW-1:0]    req0_vrb,
    input  logic [VSFX_INS_W-1:0] req0_ins,
    input  logic [VSFX_TAG_W-1:0] req0_tag,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [VSFX_DW-1:0]    req1_vra,
    input  logic [VSFX_DW-1:0]    req1_vrb,
    input  logic [VSFX_INS_W-1:0] req1_ins,
    input  logic [VSFX_TAG_W-1:0] req1_tag,
    output logic                  vsfx_en,
    output logic [VSFX_DW-1:0]    vsfx_vra,
    output logic [VSFX_DW-1:0]    vsfx_vrb,
    output logic [VSFX_INS_W-1:0] vsfx_ins,
    input  logic                  vsfx_vrt_en,
    input  logic [VSFX_DW-1:0]    vsfx_vrt,
    input  logic                  vsfx_sat,
    input  logic [3:0]            vsfx_cr6,
    output logic                  res_valid,
    output logic                  res_id,
    output logic [VSFX_TAG_W-1:0] res_tag,
    output logic                  res_vrt_en,
    output logic [VSFX_DW-1:0]    res_vrt,
    output logic [3:0]            res_cr6,
    input  logic                  flush,
    input  logic                  sat_clr,
    output logic                  sat_sticky
);
    // Handshake: a transfer happens when reqN_valid & reqN_ready; ready is only
    // ever raised for a valid requester, and never while rst or flush is high.
    logic [1:0] grant;
    vsfx_trk_t  issue_entry;
    vsfx_trk_t  trk [VSFX_LAT];
    vsfx_trk_t  tail;

    vsfx_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .block (flush),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        vsfx_en  = 1'b0;
        vsfx_vra = '0;
        vsfx_vrb = '0;
        vsfx_ins = '0;
        if (grant[0]) begin
            vsfx_en  = 1'b1;
            vsfx_vra = req0_vra;
            vsfx_vrb = req0_vrb;
            vsfx_ins = req0_ins;
        end else if (grant[1]) begin
            vsfx_en  = 1'b1;
            vsfx_vra = req1_vra;
            vsfx_vrb = req1_vrb;
            vsfx_ins = req1_ins;
        end
    end

    always_comb begin
        issue_entry.valid = |grant;
        issue_entry.id    = grant[1];
        issue_entry.tag   = grant[1] ? req1_tag : req0_tag;
    end

    // Entry loaded at the end of the issue cycle sits at the tail VSFX_LAT cycles later.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < VSFX_LAT; i++) begin
                trk[i] <= '0;
            end
        end else begin
            trk[0] <= issue_entry;
            for (int i = 1; i < VSFX_LAT; i++) begin
                trk[i] <= trk[i-1];
            end
        end
    end

    assign tail = trk[VSFX_LAT-1];

    always_comb begin
        res_valid  = tail.valid;
        res_id     = 1'b0;
        res_tag    = '0;
        res_vrt_en = 1'b0;
        res_vrt    = '0;
        res_cr6    = '0;
        if (tail.valid) begin
            res_id     = tail.id;
            res_tag    = tail.tag;
            res_vrt_en = vsfx_vrt_en;
            res_vrt    = vsfx_vrt;
            res_cr6    = vsfx_cr6;
        end
    end

    // A qualifying saturation beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_sticky <= 1'b0;
        end else if (res_valid && vsfx_sat) begin
            sat_sticky <= 1'b1;
        end else if (sat_clr) begin
            sat_sticky <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vsfx_issue_arb.sv
// Directed plus random bench for vsfx_issue_arb with a due-cycle result scoreboard.
module tb_vsfx_issue_arb;
  localparam int LAT = 2;
  localparam int EW  = 21;

  logic         clk;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_vra, req0_vrb, req1_vra, req1_vrb;
  logic [7:0]   req0_ins, req1_ins;
  logic [3:0]   req0_tag, req1_tag;
  logic         vsfx_en;
  logic [127:0] vsfx_vra, vsfx_vrb;
  logic [7:0]   vsfx_ins;
  logic         vsfx_vrt_en;
  logic [127:0] vsfx_vrt;
  logic         vsfx_sat;
  logic [3:0]   vsfx_cr6;
  logic         res_valid, res_id, res_vrt_en;
  logic [3:0]   res_tag, res_cr6;
  logic [127:0] res_vrt;
  logic         flush, sat_clr, sat_sticky;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic m_ptr = 1'b0;
  logic m_sat = 1'b0;
  logic sat_known = 1'b0;
  logic [EW-1:0] exp_q[$];

  vsfx_issue_arb #(.VSFX_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_vra(req0_vra),
    .req0_vrb(req0_vrb), .req0_ins(req0_ins), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_vra(req1_vra),
    .req1_vrb(req1_vrb), .req1_ins(req1_ins), .req1_tag(req1_tag),
    .vsfx_en(vsfx_en), .vsfx_vra(vsfx_vra), .vsfx_vrb(vsfx_vrb), .vsfx_ins(vsfx_ins),
    .vsfx_vrt_en(vsfx_vrt_en), .vsfx_vrt(vsfx_vrt), .vsfx_sat(vsfx_sat), .vsfx_cr6(vsfx_cr6),
    .res_valid(res_valid), .res_id(res_id), .res_tag(res_tag), .res_vrt_en(res_vrt_en),
    .res_vrt(res_vrt), .res_cr6(res_cr6),
    .flush(flush), .sat_clr(sat_clr), .sat_sticky(sat_sticky)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // driver: one clock cycle of stimulus, checks in the low phase, model update for the edge
  task automatic step(input logic v0, input logic v1, input logic [3:0] t0, input logic [3:0] t1,
                      input logic fl, input logic sc, input logic sat, input logic r);
    logic          win_v;
    logic          win_id;
    logic          exp_rv;
    logic [EW-1:0] e;
    logic [15:0]   due;
    @(negedge clk);
    rst = r; flush = fl; sat_clr = sc; vsfx_sat = sat;
    req0_valid = v0; req1_valid = v1; req0_tag = t0; req1_tag = t1;
    req0_vra = rnd128(); req0_vrb = rnd128(); req0_ins = 8'($urandom);
    req1_vra = rnd128(); req1_vrb = rnd128(); req1_ins = 8'($urandom);
    vsfx_vrt = rnd128(); vsfx_vrt_en = 1'($urandom); vsfx_cr6 = 4'($urandom);

    win_v = 1'b0; win_id = 1'b0;
    if (!r && !fl) begin
      if (v0 && v1) begin win_v = 1'b1; win_id = m_ptr; end
      else if (v0) begin win_v = 1'b1; win_id = 1'b0; end
      else if (v1) begin win_v = 1'b1; win_id = 1'b1; end
    end
    #1;
    chk("req0_ready", 128'(req0_ready), 128'(win_v && !win_id));
    chk("req1_ready", 128'(req1_ready), 128'(win_v && win_id));
    chk("vsfx_en", 128'(vsfx_en), 128'(win_v));
    chk("vsfx_vra", vsfx_vra, !win_v ? 128'd0 : (win_id ? req1_vra : req0_vra));
    chk("vsfx_vrb", vsfx_vrb, !win_v ? 128'd0 : (win_id ? req1_vrb : req0_vrb));
    chk("vsfx_ins", 128'(vsfx_ins), !win_v ? 128'd0 : 128'(win_id ? req1_ins : req0_ins));

    exp_rv = 1'b0;
    if (!r) begin
      e = '0;
      if (exp_q.size() > 0) begin
        due = exp_q[0][20:5];
        if (due == cyc[15:0]) begin
          e = exp_q.pop_front();
          exp_rv = 1'b1;
        end
      end
      chk("res_valid", 128'(res_valid), 128'(exp_rv));
      if (exp_rv) begin
        chk("res_id", 128'(res_id), 128'(e[4]));
        chk("res_tag", 128'(res_tag), 128'(e[3:0]));
      end
      chk("res_vrt", res_vrt, exp_rv ? vsfx_vrt : 128'd0);
      chk("res_vrt_en", 128'(res_vrt_en), 128'(exp_rv && vsfx_vrt_en));
      chk("res_cr6", 128'(res_cr6), exp_rv ? 128'(vsfx_cr6) : 128'd0);
      if (sat_known) chk("sat_sticky", 128'(sat_sticky), 128'(m_sat));
    end

    if (r) begin
      exp_q.delete();
      m_ptr = 1'b0;
      m_sat = 1'b0;
      sat_known = 1'b1;
    end else begin
      if (exp_rv && sat) m_sat = 1'b1;
      else if (sc) m_sat = 1'b0;
      if (fl) exp_q.delete();
      if (win_v) begin
        due = 16'(cyc + LAT);
        exp_q.push_back({due, win_id, win_id ? t1 : t0});
        m_ptr = ~win_id;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; sat_clr = 1'b0; vsfx_sat = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_tag = '0; req1_tag = '0;
    req0_vra = '0; req0_vrb = '0; req0_ins = '0; req1_vra = '0; req1_vrb = '0; req1_ins = '0;
    vsfx_vrt = '0; vsfx_vrt_en = 1'b0; vsfx_cr6 = '0;

    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 3, 5, 0, 0, 0, 1);

    // both valid from reset: grants alternate 0,1,0,1, results follow LAT later
    for (int i = 0; i < 4; i++) step(1, 1, 3, 5, 0, 0, 0, 0);
    idle(3);

    // req1 alone three times, then both valid: pointer has moved to 0
    for (int i = 0; i < 3; i++) step(0, 1, 2, 9, 0, 0, 0, 0);
    step(1, 1, 7, 8, 0, 0, 0, 0);
    idle(3);

    // issue then flush: both operations lost, saturation on dead slots ignored
    step(1, 0, 4, 0, 0, 0, 0, 0);
    step(1, 1, 6, 1, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);

    // flush coinciding with a tail result: result still emitted and sets SAT
    step(0, 1, 0, 12, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 13, 0, 1, 0, 1, 0);
    idle(3);
    step(0, 0, 0, 0, 0, 1, 0, 0);

    // saturating result with simultaneous clear, then clear alone
    step(1, 0, 10, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);

    // reset with two operations in flight and sticky SAT set
    step(1, 0, 11, 0, 0, 0, 0, 0);
    step(1, 0, 14, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 15, 15, 0, 0, 0, 1);
    idle(3);
    step(1, 1, 1, 2, 0, 0, 0, 0);
    idle(3);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
           1'($urandom), $urandom_range(0, 29) == 0);
    end
    idle(LAT + 1);

    chk("exp_q_drained", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vsfx_issue_arb.md
VSFX_ISSUE_ARB -- requirements
Module: vsfx_issue_arb

Interface
REQ-001 Parameter VSFX_LAT, default 2: fixed vsfx issue-to-result latency in cycles, legal range 1..4.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 reqN_valid  in  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  out  1  grant to requester N; a transfer occurs when valid&ready.
REQ-006 reqN_vra, reqN_vrb  in  128 each  source operands.
REQ-007 reqN_ins  in  8  opcode field, ins[21:25],ins[28:30].
REQ-008 reqN_tag  in  4  requester-local destination tag.
REQ-009 vsfx_en  out  1  issue strobe to the vsfx unit.
REQ-010 vsfx_vra, vsfx_vrb  out  128 each; vsfx_ins  out  8  issued operation.
REQ-011 vsfx_vrt_en  in  1; vsfx_vrt  in  128; vsfx_sat  in  1; vsfx_cr6  in  4  unit results, valid VSFX_LAT cycles after issue.
REQ-012 res_valid  out  1; res_id  out  1 (requester); res_tag  out  4; res_vrt_en  out  1; res_vrt  out  128; res_cr6  out  4  routed result.
REQ-013 flush  in  1  kill all in-flight operations and block issue this cycle.
REQ-014 sat_clr  in  1  clear sticky saturation bit.
REQ-015 sat_sticky  out  1  accumulated VSCR[SAT].

Function
REQ-016 Issue is combinational: at most one reqN_ready high per cycle; reqN_ready never high unless reqN_valid high (ready depends on valid by design).
REQ-017 Arbitration is round-robin on a 1-bit priority pointer; only one valid -> that requester wins; both valid -> pointer's requester wins.
REQ-018 Pointer moves to the other requester after each grant and is unchanged in cycles with no grant.
REQ-019 Winning requester's vra/vrb/ins drive vsfx_* with vsfx_en=1 in the grant cycle; otherwise vsfx_en=0 and vsfx_vra/vrb/ins are 0.
REQ-020 Unit is fully pipelined: one issue per cycle with no bubbles.
REQ-021 A tracking shift register of depth VSFX_LAT holds {valid,id,tag} per issue; an entry issued in cycle t reaches the tail in cycle t+VSFX_LAT.
REQ-022 res_valid = tail.valid; res_id/res_tag come from the tail entry; res_vrt_en/res_vrt/res_cr6 pass vsfx_* through when res_valid, else 0.
REQ-023 Results cannot be back-pressured; the consumer accepts every res_valid cycle.
REQ-024 flush=1: no grant that cycle; every tracking entry is invalidated at the next edge, so no result from an operation issued at or before the flush cycle appears.
REQ-025 sat_sticky sets at the edge after a cycle with res_valid=1 and vsfx_sat=1; results with res_valid=0, including flushed ones, never set it.
REQ-026 sat_clr and a qualifying set in the same cycle: set wins and sat_sticky=1.
REQ-027 flush and res_valid in the same cycle: the tail result still outputs and counts toward SAT (it was already at the tail).

Reset
REQ-028 rst takes priority over all inputs; at the edge it clears every tracking valid bit, sets pointer=0 (requester 0 first) and sets sat_sticky=0.
REQ-029 While rst=1 both reqN_ready=0 and vsfx_en=0, and res_valid=0 from the next cycle on; no partially-tracked operation survives.

Structure
REQ-030 Shared package holds VSFX_INS_W=8, VSFX_DW=128, VSFX_TAG_W=4 and the tracking-entry struct {valid,id,tag}.
REQ-031 One sub-module, vsfx_rr_arb2: a 2-way round-robin arbiter with pointer state; tracking pipe and SAT logic stay in the top level.
REQ-032 The vsfx unit is instantiated outside this block.

Verification
REQ-033 Both valid from reset, tags 3/5 held 4 cycles -> grants 0,1,0,1; with VSFX_LAT=2, res_id 0,1,0,1 in cycles 2..5.
REQ-034 Only req1 valid for 3 cycles -> req1 granted every cycle; then both valid -> req0 wins next, the pointer having moved to 0.
REQ-035 Issue at t=0,1, flush at t=1 -> the t=1 issue is blocked, res_valid=0 at t=2,3 and sat_sticky is unchanged.
REQ-036 Result with vsfx_sat=1 and simultaneous sat_clr -> sat_sticky=1; sat_clr alone next cycle -> 0.
REQ-037 rst asserted with two operations in flight -> no res_valid afterwards, pointer=0 and sat_sticky=0.
